// File: rtl/arith_serial_unit.sv
// rtl/arith_serial_unit.sv - digit-serial add/sub/neg/inc unit
// Processes DIGIT bits per cycle; result and NZCV-style flags are held until out_ready.
module arith_serial_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout, dig_cmsb;
  logic             last_digit;

  assign last_digit = (k_q == CW'(N - 1));

  // Ripple adder for the current digit; dig_cmsb is the carry into the digit's top bit,
  // which on the last digit is the carry into bit WIDTH-1.
  always_comb begin
    logic c;
    dig_a    = '0;
    dig_b    = '0;
    dig_sum  = '0;
    dig_cmsb = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (k_q == CW'(j)) begin
        dig_a = opa_q[j*DIGIT +: DIGIT];
        dig_b = opb_q[j*DIGIT +: DIGIT];
      end
    end
    c = cy_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) dig_cmsb = c;
      dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c;
      c = (dig_a[i] & dig_b[i]) | (c & (dig_a[i] ^ dig_b[i]));
    end
    dig_cout = c;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cy_d     = cy_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = op[1] ? '0 : a;
          opb_d   = (op[1] ^ op[0]) ? ~b : b;
          cy_d    = (op != 2'b00);
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < N; j++) begin
          if (k_q == CW'(j)) result_d[j*DIGIT +: DIGIT] = dig_sum;
        end
        cy_d = dig_cout;
        k_d  = k_q + CW'(1);
        if (last_digit) begin
          k_d     = '0;
          state_d = DONE;
          carry_d = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          zero_d  = (result_d == '0);
          neg_d   = result_d[WIDTH-1];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_arith_serial_unit.sv
// tb/tb_arith_serial_unit.sv - bench for arith_serial_unit (32/8 and 16/4 instances)
module tb_arith_serial_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [1:0]  op;
  logic        carry, overflow, zero, negative;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [1:0]  op16;
  logic        carry16, overflow16, zero16, negative16;

  int passed = 0;
  int total  = 0;

  arith_serial_unit #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  arith_serial_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .carry(carry16), .overflow(overflow16), .zero(zero16),
    .negative(negative16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: signed/unsigned arithmetic on wide integers, carry = unsigned result fits
  // beyond 32 bits (or no borrow), overflow = signed result out of 32-bit range.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop,
                       output logic [31:0] r, output logic c, output logic v,
                       output logic z, output logic n);
    longint ua, ub, sa, sb, u, s;
    longint two32;
    two32 = 64'sd1 <<< 32;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00:   begin u = ua + ub; s = sa + sb; c = (u >= two32); end
      2'b01:   begin u = ua - ub; s = sa - sb; c = (ua >= ub);   end
      2'b10:   begin u = -ub;     s = -sb;     c = (ub == 0);    end
      default: begin u = ub + 1;  s = sb + 1;  c = (u >= two32); end
    endcase
    r = u[31:0];
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    z = (r == 32'd0);
    n = r[31];
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [1:0] top, input bit hold);
    logic [31:0] er;
    logic        ec, ev, ez, en;
    int          lat;
    model(ta, tb_v, top, er, ec, ev, ez, en);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk("in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 4);
    chk("result", result, er);
    chk("carry", carry, ec);
    chk("overflow", overflow, ev);
    chk("zero", zero, ez);
    chk("negative", negative, en);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'($urandom); a = $urandom; b = $urandom; op = 2'($urandom);
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_result", {result, carry, overflow, zero, negative}, {er, ec, ev, ez, en});
      end
    end
    out_ready = 1'b1; in_valid = 1'b1; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  initial begin
    bit seen;
    int lat16;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; op16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {result, carry, overflow, zero, negative}, 36'd0);
    chk("rst16_in_ready", in_ready16, 1);
    rst_n = 1'b1;

    run_op(32'd30, 32'd16, 2'b00, 1'b0);
    run_op(32'd5, 32'd7, 2'b01, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 2'b10, 1'b0);
    run_op(32'd0, 32'd0, 2'b10, 1'b0);
    run_op(32'h1234_5678, 32'hFFFF_FFFF, 2'b11, 1'b0);
    run_op(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b11, 1'b0);
    run_op(32'h8000_0000, 32'd1, 2'b01, 1'b1);

    // Abort mid-operation: reset lands in the second RUN cycle.
    @(negedge clk);
    a = 32'd30; b = 32'd16; op = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_outputs", {result, carry, overflow, zero, negative}, 36'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(32'd30, 32'd16, 2'b00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = 32'h7FFF_FFFF;
      run_op(ra, rb, 2'($urandom), 1'b0);
    end

    // 16-bit, 4-bit digit instance
    @(negedge clk);
    a16 = 16'd30; b16 = 16'd16; op16 = 2'b00; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat16 = 0;
    while (!out_valid16 && lat16 < 20) begin
      @(negedge clk);
      lat16++;
    end
    chk("w16_latency", lat16, 4);
    chk("w16_result", result16, 16'd46);
    chk("w16_flags", {carry16, overflow16, zero16, negative16}, 4'b0000);
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;
    chk("w16_release", out_valid16, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
